object_entry_queue: RTL and testbench

Parametrised circular queue of decoded protobuf field descriptors. It sits between the field-descriptor decoder and the serializer datapath, and replaces the fixed 64-row object buffer. The new block adds a valid/ready push and pop handshake, wrap-around head and tail pointers, occupancy and almost-full reporting, a synchronous flush, and a running count of nested entries so the serializer can pre-allocate sub-message frames.

---
 rtl/pb_pkg.sv | 18 +
 rtl/entry_ram.sv | 25 ++
 rtl/object_entry_queue.sv | 102 ++++++++++
 tb/tb_object_entry_queue.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pb_pkg.sv
// Shared protobuf serializer types: decoded field-descriptor entry and field widths.
package pb_pkg;

  localparam int FIELD_ID_W   = 29;
  localparam int FIELD_TYPE_W = 5;
  localparam int SIZE_W       = 16;
  localparam int TYPE_TABLE_W = 64;

  typedef struct packed {
    logic                    valid;
    logic [FIELD_ID_W-1:0]   field_id;
    logic [FIELD_TYPE_W-1:0] field_type;
    logic [SIZE_W-1:0]       size;
    logic                    nested;
    logic [TYPE_TABLE_W-1:0] nested_type_table;
  } obj_entry_t;

endpackage

// File: rtl/entry_ram.sv
// Entry storage: DEPTH x obj_entry_t register array, one write port, one async read port.
module entry_ram
  import pb_pkg::*;
#(
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  obj_entry_t    wdata,
  input  logic [AW-1:0] raddr,
  output obj_entry_t    rdata
);

  // Contents are intentionally not reset; occupancy lives in the queue control.
  obj_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/object_entry_queue.sv
// Circular queue of decoded field descriptors with valid/ready push/pop, flush,
// registered status flags and a running count of nested entries.
module object_entry_queue
  import pb_pkg::*;
#(
  parameter  int DEPTH        = 64,
  parameter  int AFULL_THRESH = DEPTH - 4,
  localparam int AW           = $clog2(DEPTH),
  localparam int CW           = AW + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  obj_entry_t    in_entry,
  output logic          out_valid,
  input  logic          out_ready,
  output obj_entry_t    out_entry,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic [CW-1:0] nested_count
);

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] nested_q, nested_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          afull_q, afull_d;
  logic          push, pop, nest_inc, nest_dec;

  // Handshakes depend only on registered flags, so no input reaches an output.
  assign push     = in_valid && !full_q;
  assign pop      = out_ready && !empty_q;
  assign nest_inc = push && in_entry.nested;
  assign nest_dec = pop && out_entry.nested;

  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    nested_d = nested_q;
    if (flush) begin
      head_d   = '0;
      tail_d   = '0;
      count_d  = '0;
      nested_d = '0;
    end else begin
      if (push) tail_d = tail_q + AW'(1);
      if (pop)  head_d = head_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
      if (nest_inc && !nest_dec)      nested_d = nested_q + CW'(1);
      else if (nest_dec && !nest_inc) nested_d = nested_q - CW'(1);
    end
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
    afull_d = (count_d >= CW'(AFULL_THRESH));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      nested_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      nested_q <= nested_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
    end
  end

  entry_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (push && !flush),
    .waddr (tail_q),
    .wdata (in_entry),
    .raddr (head_q),
    .rdata (out_entry)
  );

  assign in_ready     = !full_q;
  assign out_valid    = !empty_q;
  assign count        = count_q;
  assign nested_count = nested_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;

endmodule

// File: tb/tb_object_entry_queue.sv
// Directed bench for object_entry_queue (DEPTH=4, AFULL_THRESH=3) with a scoreboard-driven pop monitor.
module tb_object_entry_queue;
  import pb_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  obj_entry_t    in_entry;
  logic          out_valid;
  logic          out_ready;
  obj_entry_t    out_entry;
  logic [CW-1:0] count;
  logic          full, empty, almost_full;
  logic [CW-1:0] nested_count;

  int errors = 0;
  int checks = 0;
  obj_entry_t sb_q[$];

  object_entry_queue #(.DEPTH(DEPTH), .AFULL_THRESH(3)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_entry     (in_entry),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_entry    (out_entry),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .nested_count (nested_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: a pop will fire on the coming edge; compare head against the scoreboard.
  always @(negedge clk) begin
    if (reset_n && !flush && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_pop", 1, 0);
      end else begin
        obj_entry_t exp_e;
        exp_e = sb_q.pop_front();
        check("pop_field_id", int'(out_entry.field_id), int'(exp_e.field_id));
        check("pop_nested", int'(out_entry.nested), int'(exp_e.nested));
        check("pop_size", int'(out_entry.size), int'(exp_e.size));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a push; record it in the scoreboard only when the bench knows it is accepted.
  task automatic drive_push(input int fid, input logic nst, input logic accept);
    obj_entry_t e;
    e = '0;
    e.valid             = 1'b1;
    e.field_id          = FIELD_ID_W'(fid);
    e.field_type        = FIELD_TYPE_W'(fid % 19);
    e.size              = SIZE_W'(fid * 7 + 3);
    e.nested            = nst;
    e.nested_type_table = {32'hCAFE_0000 | 32'(fid), 32'(fid)};
    in_valid = 1'b1;
    in_entry = e;
    if (accept) sb_q.push_back(e);
  endtask

  initial begin
    reset_n   = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_entry  = '0;
    #2 reset_n = 1'b0;
    #1;
    check("rst_count", int'(count), 0);
    check("rst_empty", int'(empty), 1);
    check("rst_full", int'(full), 0);
    check("rst_afull", int'(almost_full), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_nested", int'(nested_count), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;

    // Fill to full.
    for (int i = 1; i <= 4; i++) begin
      drive_push(i, 1'b0, 1'b1);
      step();
    end
    check("fill_count", int'(count), 4);
    check("fill_full", int'(full), 1);
    check("fill_in_ready", int'(in_ready), 0);
    check("fill_afull", int'(almost_full), 1);
    check("fill_head", int'(out_entry.field_id), 1);

    // Push while full with a simultaneous pop: push refused.
    drive_push(5, 1'b0, 1'b0);
    out_ready = 1'b1;
    step();
    check("fullpop_count", int'(count), 3);
    check("fullpop_in_ready", int'(in_ready), 1);
    check("fullpop_head", int'(out_entry.field_id), 2);
    check("fullpop_afull", int'(almost_full), 1);

    // Concurrent push/pop for 10 cycles, pointers wrap.
    for (int i = 0; i < 10; i++) begin
      drive_push(10 + i, 1'b0, 1'b1);
      step();
      check("stream_count", int'(count), 3);
    end
    in_valid = 1'b0;
    repeat (3) step();
    out_ready = 1'b0;
    check("drain_count", int'(count), 0);
    check("drain_empty", int'(empty), 1);
    check("drain_out_valid", int'(out_valid), 0);

    // Nested accounting.
    drive_push(30, 1'b1, 1'b1); step();
    drive_push(31, 1'b0, 1'b1); step();
    drive_push(32, 1'b1, 1'b1); step();
    in_valid = 1'b0;
    check("nest_after3", int'(nested_count), 2);
    out_ready = 1'b1;
    step();
    check("nest_pop1", int'(nested_count), 1);
    step();
    check("nest_pop0", int'(nested_count), 1);
    check("nest_cnt1", int'(count), 1);
    drive_push(33, 1'b1, 1'b1);
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("nest_both", int'(nested_count), 1);
    check("cnt1_both", int'(count), 1);
    check("cnt1_head", int'(out_entry.field_id), 33);

    // Flush with a concurrent push and pop.
    drive_push(34, 1'b0, 1'b1); step();
    drive_push(35, 1'b1, 1'b1); step();
    check("preflush_count", int'(count), 3);
    drive_push(99, 1'b1, 1'b0);
    flush     = 1'b1;
    out_ready = 1'b1;
    step();
    sb_q.delete();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("flush_count", int'(count), 0);
    check("flush_empty", int'(empty), 1);
    check("flush_nested", int'(nested_count), 0);
    check("flush_out_valid", int'(out_valid), 0);
    drive_push(40, 1'b0, 1'b1); step();
    in_valid = 1'b0;
    check("postflush_count", int'(count), 1);
    check("postflush_head", int'(out_entry.field_id), 40);
    check("postflush_nested", int'(nested_count), 0);

    // Asynchronous reset between edges.
    drive_push(41, 1'b1, 1'b1); step();
    in_valid = 1'b0;
    check("prereset_count", int'(count), 2);
    #2 reset_n = 1'b0;
    #1;
    sb_q.delete();
    check("async_count", int'(count), 0);
    check("async_empty", int'(empty), 1);
    check("async_out_valid", int'(out_valid), 0);
    check("async_in_ready", int'(in_ready), 1);
    check("async_nested", int'(nested_count), 0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk) #1;

    // Queue usable after reset.
    drive_push(50, 1'b1, 1'b1); step();
    in_valid  = 1'b0;
    check("final_nested", int'(nested_count), 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("final_empty", int'(empty), 1);
    check("final_nested0", int'(nested_count), 0);
    check("sb_drained", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
